// File: rtl/alu_in_pkg_hdl.sv
// -----------------------------------------------------------------------------
// alu_in_pkg_hdl
// Shared types for the alu_core block and its initiator.
//   alu_in_op_t : 3-bit operation code (no_op, add, and, xor, mul, 3 reserved)
//   alu_state_t : control state of alu_core
//   is_reserved : true for the reserved opcodes 5..7
// -----------------------------------------------------------------------------
package alu_in_pkg_hdl;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_AND  = 3'd2,
        OP_XOR  = 3'd3,
        OP_MUL  = 3'd4,
        OP_RSV5 = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } alu_in_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

    function automatic logic is_reserved(input alu_in_op_t o);
        return (o == OP_RSV5) || (o == OP_RSV6) || (o == OP_RSV7);
    endfunction

endpackage

// File: rtl/alu_core_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_core_mul_seq
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst (async, active-low)  clock / reset
//   clr      sync clear, discards any multiplication in flight
//   start    load a/b; the first partial product is added on this same edge
//   a, b     W-bit unsigned operands
//   busy     high while partial products remain to be accumulated
//   product  2W-bit result, valid once busy is low after a start
// The load edge handles bit 0 of b, the following W-1 edges handle the rest,
// so the product is final W-1 edges after start and the owner sees busy low
// on its W-th cycle in the multiply state.
// -----------------------------------------------------------------------------
module alu_core_mul_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc_q,    acc_d;
    logic [2*W-1:0] mcand_q,  mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q,    cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (clr) begin
            acc_d    = '0;
            mcand_d  = '0;
            mplier_d = '0;
            cnt_d    = '0;
        end else if (start) begin
            acc_d    = b[0] ? {{W{1'b0}}, a} : '0;
            mcand_d  = {{W{1'b0}}, a} << 1;
            mplier_d = b >> 1;
            cnt_d    = CW'(W - 1);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy    = (cnt_q != '0);
    assign product = acc_q;

endmodule

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Small multi-cycle ALU with a valid/ready accept handshake and a done pulse.
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous active-low reset
//   alu_rst  synchronous active-high soft reset from the initiator
//   ready    registered; high when an operation can be accepted
//   valid    initiator presents op/a/b
//   op       operation code (alu_in_op_t)
//   a, b     W-bit unsigned operands
//   done     one-cycle pulse; result/err valid while high
//   result   2W-bit result, held until the next done or reset
//   err      high with done for a reserved opcode
// Latency from the accept edge k: add/and/xor/reserved -> done after k+1,
// mul -> done after k+W; done always lasts one cycle, ready returns as it falls.
// -----------------------------------------------------------------------------
module alu_core
    import alu_in_pkg_hdl::*;
#(
    parameter int ALU_IN_OP_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alu_rst,
    output logic                           ready,
    input  logic                           valid,
    input  logic [2:0]                     op,
    input  logic [ALU_IN_OP_WIDTH-1:0]     a,
    input  logic [ALU_IN_OP_WIDTH-1:0]     b,
    output logic                           done,
    output logic [2*ALU_IN_OP_WIDTH-1:0]   result,
    output logic                           err
);

    localparam int W                = ALU_IN_OP_WIDTH;
    localparam int ALU_RESULT_WIDTH = 2 * ALU_IN_OP_WIDTH;
    localparam int RW               = ALU_RESULT_WIDTH;

    alu_state_t     state_q, state_d;
    alu_in_op_t     op_q;
    logic [W-1:0]   a_q, b_q;
    logic           ready_q, ready_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [RW-1:0]  result_q, result_d;
    logic [RW-1:0]  exec_val;

    alu_in_op_t     op_in;
    logic           accept;
    logic           mul_start;
    logic           mul_busy;
    logic [RW-1:0]  mul_product;

    assign op_in     = alu_in_op_t'(op);
    // ready_q is only ever high in IDLE, so it doubles as the state qualifier.
    assign accept    = valid && ready_q && !alu_rst;
    assign mul_start = accept && (op_in == OP_MUL);

    alu_core_mul_seq #(
        .W (W)
    ) u_mul_seq (
        .clk     (clk),
        .rst     (rst),
        .clr     (alu_rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .product (mul_product)
    );

    // Single-cycle datapath works only from the captured operands, so input
    // changes after the accept edge cannot disturb the result.
    always_comb begin
        exec_val = '0;
        case (op_q)
            OP_ADD:  exec_val = RW'(a_q) + RW'(b_q);
            OP_AND:  exec_val = RW'(a_q & b_q);
            OP_XOR:  exec_val = RW'(a_q ^ b_q);
            default: exec_val = '0;
        endcase
    end

    // State register plus the registered outputs and captured operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            if (accept) begin
                op_q <= op_in;
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

    // Next-state logic; the soft reset overrides every transition.
    always_comb begin
        state_d = state_q;
        if (alu_rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_in)
                            OP_NOP:  state_d = ST_IDLE;
                            OP_MUL:  state_d = ST_MUL;
                            default: state_d = ST_EXEC;
                        endcase
                    end
                end
                ST_EXEC: state_d = ST_DONE;
                ST_MUL:  if (!mul_busy) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic, computed one cycle ahead so every output is a flop.
    always_comb begin
        ready_d  = (state_d == ST_IDLE) && !alu_rst;
        done_d   = (state_d == ST_DONE);
        err_d    = 1'b0;
        result_d = result_q;
        if (alu_rst) begin
            result_d = '0;
        end else if (state_q == ST_EXEC) begin
            result_d = exec_val;
            err_d    = is_reserved(op_q);
        end else if ((state_q == ST_MUL) && !mul_busy) begin
            result_d = mul_product;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule
